// File: rtl/mem_stage.sv
// mem_stage: MEM-stage controller with req/ack data access, stack pointer and write-back register
module mem_stage #(
  parameter logic [31:0] SP_INIT = 32'h0000_FFFC,
  parameter logic [31:0] SP_STEP = 32'd4,
  parameter int          TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] st_data_in,
  input  logic [3:0]  reg_dst_in,
  input  logic        reg_wr_in,
  input  logic        wb_sel_in,
  input  logic        mem_addr_sel_in,
  input  logic        mem_wr_in,
  input  logic [1:0]  sp_select_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [3:0]  reg_dst_out,
  output logic        reg_wr_out,
  output logic [31:0] sp_out,
  output logic        mem_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] sp_q, wb_data_q;
  logic [3:0]  reg_dst_q;
  logic        reg_wr_q, err_q;
  logic        access, push, pop, done, timeout;
  // Request, address and stall decode; the request is gated by reset so it drops immediately
  always_comb begin
    access    = wb_sel_in | mem_wr_in;
    push      = sp_select_in == 2'b01;
    pop       = sp_select_in == 2'b10;
    mem_req   = rst_n & (access | state_q == WAIT);
    mem_we    = mem_wr_in;
    mem_wdata = st_data_in;
    mem_addr  = !mem_addr_sel_in ? alu_out_in : push ? sp_q - SP_STEP : sp_q;
    done      = mem_req & mem_ack;
    timeout   = rst_n & state_q == WAIT & !mem_ack & cnt_q == 8'(TIMEOUT - 1);
    stall_out = mem_req & !mem_ack & !timeout;
  end
  // FSM, timeout counter, stack pointer and registered write-back; SP moves only on an acked access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sp_q      <= SP_INIT;
      wb_data_q <= '0;
      reg_dst_q <= '0;
      reg_wr_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= stall_out ? WAIT : IDLE;
      cnt_q   <= (state_q == WAIT && stall_out) ? cnt_q + 8'd1 : '0;
      err_q   <= timeout;
      if (done && push) sp_q <= sp_q - SP_STEP;
      if (done && pop) sp_q <= sp_q + SP_STEP;
      if (!stall_out && !timeout) begin
        wb_data_q <= wb_sel_in ? mem_rdata : alu_out_in;
        reg_dst_q <= reg_dst_in;
        reg_wr_q  <= reg_wr_in;
      end else begin
        reg_wr_q  <= 1'b0;
      end
    end
  end
  assign wb_data_out = wb_data_q;
  assign reg_dst_out = reg_dst_q;
  assign reg_wr_out  = reg_wr_q;
  assign sp_out      = sp_q;
  assign mem_err     = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_out_in, st_data_in, mem_rdata;
  logic [3:0]  reg_dst_in;
  logic        reg_wr_in, wb_sel_in, mem_addr_sel_in, mem_wr_in, mem_ack;
  logic [1:0]  sp_select_in;
  logic        mem_req, mem_we, stall_out, reg_wr_out, mem_err;
  logic [31:0] mem_addr, mem_wdata, wb_data_out, sp_out;
  logic [3:0]  reg_dst_out;
  logic        z_req, z_we, z_stall, z_wr, z_err;
  logic [31:0] z_addr, z_wdata, z_wb, z_sp;
  logic [3:0]  z_dst;
  int total = 0, bad = 0;
  int nreq, nstall, nerr;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out_in(alu_out_in), .st_data_in(st_data_in),
    .reg_dst_in(reg_dst_in), .reg_wr_in(reg_wr_in), .wb_sel_in(wb_sel_in),
    .mem_addr_sel_in(mem_addr_sel_in), .mem_wr_in(mem_wr_in), .sp_select_in(sp_select_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
    .wb_data_out(wb_data_out), .reg_dst_out(reg_dst_out), .reg_wr_out(reg_wr_out),
    .sp_out(sp_out), .mem_err(mem_err)
  );

  mem_stage #(.SP_INIT(32'h0), .TIMEOUT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .alu_out_in(alu_out_in), .st_data_in(st_data_in),
    .reg_dst_in(reg_dst_in), .reg_wr_in(reg_wr_in), .wb_sel_in(wb_sel_in),
    .mem_addr_sel_in(mem_addr_sel_in), .mem_wr_in(mem_wr_in), .sp_select_in(sp_select_in),
    .mem_req(z_req), .mem_we(z_we), .mem_addr(z_addr), .mem_wdata(z_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(z_stall),
    .wb_data_out(z_wb), .reg_dst_out(z_dst), .reg_wr_out(z_wr),
    .sp_out(z_sp), .mem_err(z_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nop(input logic [31:0] alu, input logic wr, input logic [3:0] dst);
    alu_out_in = alu; reg_wr_in = wr; reg_dst_in = dst;
    wb_sel_in = 0; mem_wr_in = 0; mem_addr_sel_in = 0; sp_select_in = 2'b00; mem_ack = 0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; st_data_in = 0; mem_rdata = 0;
    nop(32'h0, 0, 4'h0);
    #12;
    chk("rst_sp", sp_out, 32'h0000_FFFC);
    chk("rst_sp0", z_sp, 32'h0);
    chk("rst_wb", wb_data_out, 32'h0);
    chk("rst_wr", reg_wr_out, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_err", mem_err, 0);
    @(negedge clk); rst_n = 1;
    nop(32'h1234, 1, 4'd3);
    #1 chk("alu_req", mem_req, 0);
    chk("alu_stall", stall_out, 0);
    tick;
    chk("alu_wb", wb_data_out, 32'h1234);
    chk("alu_dst", reg_dst_out, 32'd3);
    chk("alu_wr", reg_wr_out, 1);
    chk("alu_sp", sp_out, 32'h0000_FFFC);
    @(negedge clk);
    alu_out_in = 32'h100; wb_sel_in = 1; reg_wr_in = 1; reg_dst_in = 4'd5;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ld_req", mem_req, 1);
      chk("ld_addr", mem_addr, 32'h100);
      chk("ld_stall", stall_out, 1);
      tick;
      chk("ld_bubble", reg_wr_out, 0);
      @(negedge clk);
    end
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_ack_stall", stall_out, 0);
    chk("ld_ack_req", mem_req, 1);
    tick;
    chk("ld_wb", wb_data_out, 32'hDEAD_BEEF);
    chk("ld_wr", reg_wr_out, 1);
    chk("ld_dst", reg_dst_out, 32'd5);
    @(negedge clk);
    nop(32'h0, 0, 4'd0);
    mem_wr_in = 1; mem_addr_sel_in = 1; sp_select_in = 2'b01; st_data_in = 32'hA5; mem_ack = 1;
    #1 chk("push_addr", mem_addr, 32'h0000_FFF8);
    chk("push_we", mem_we, 1);
    chk("push_wdata", mem_wdata, 32'hA5);
    chk("push_stall", stall_out, 0);
    chk("push_addr0", z_addr, 32'hFFFF_FFFC);
    tick;
    chk("push_sp", sp_out, 32'h0000_FFF8);
    chk("push_sp0", z_sp, 32'hFFFF_FFFC);
    @(negedge clk);
    mem_wr_in = 0; wb_sel_in = 1; sp_select_in = 2'b10; reg_wr_in = 1; reg_dst_in = 4'd7;
    mem_rdata = 32'h55; mem_ack = 1;
    #1 chk("pop_addr", mem_addr, 32'h0000_FFF8);
    chk("pop_we", mem_we, 0);
    chk("pop_addr0", z_addr, 32'hFFFF_FFFC);
    tick;
    chk("pop_sp", sp_out, 32'h0000_FFFC);
    chk("pop_sp0", z_sp, 32'h0);
    chk("pop_wb", wb_data_out, 32'h55);
    @(negedge clk);
    nop(32'h200, 1, 4'd9);
    wb_sel_in = 1;
    nreq = 0; nstall = 0; nerr = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1 nreq += int'(mem_req); nstall += int'(stall_out);
      tick;
      nerr += int'(mem_err);
    end
    chk("to_err_pulse", mem_err, 1);
    chk("to_wr", reg_wr_out, 0);
    chk("to_sp", sp_out, 32'h0000_FFFC);
    @(negedge clk);
    nop(32'h77, 1, 4'd2);
    tick;
    nerr += int'(mem_err);
    chk("to_req_cycles", nreq, 5);
    chk("to_stall_cycles", nstall, 4);
    chk("to_err_cycles", nerr, 1);
    chk("resume_wb", wb_data_out, 32'h77);
    chk("resume_wr", reg_wr_out, 1);
    @(negedge clk);
    nop(32'h300, 1, 4'd4);
    wb_sel_in = 1;
    tick;
    chk("rw_stall", stall_out, 1);
    #2 rst_n = 0;
    #1 chk("rw_req", mem_req, 0);
    chk("rw_stall_rst", stall_out, 0);
    chk("rw_wb", wb_data_out, 32'h0);
    chk("rw_wr", reg_wr_out, 0);
    @(negedge clk);
    nop(32'h0, 0, 4'd0);
    rst_n = 1; mem_ack = 1; mem_rdata = 32'hBAD;
    tick;
    chk("late_ack_wb", wb_data_out, 32'h0);
    chk("late_ack_wr", reg_wr_out, 0);
    chk("late_ack_sp", sp_out, 32'h0000_FFFC);
    chk("late_ack_err", mem_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

MEM-stage controller fed directly by the EX/MEM pipeline register. It issues at most one data-memory access per instruction through a req/ack handshake and owns the architectural stack pointer (push/pop). While an access is outstanding it stalls the front of the pipeline, and it registers the write-back result toward the MEM/WB stage.

## Interface
- SP_INIT, 32'h0000_FFFC, stack pointer reset value
- SP_STEP, 4, byte delta applied on push/pop
- TIMEOUT, 255, maximum WAIT cycles without ack before abort (1..255, fits 8-bit counter)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_out_in  in  32  ALU result / effective address from EX/MEM
- st_data_in  in  32  store data
- reg_dst_in  in  4  destination register
- reg_wr_in, wb_sel_in, mem_addr_sel_in, mem_wr_in  in  1 each  EX/MEM control (wb_sel=1: load)
- sp_select_in  in  2  00 none, 01 push, 10 pop, 11 treated as 00
- mem_req  out  1  memory request (combinational)
- mem_we  out  1  1 = write
- mem_addr  out  32  byte address
- mem_wdata  out  32  = st_data_in
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe
- stall_out  out  1  holds PC/IF/ID/EX and EX/MEM
- wb_data_out  out  32  registered write-back value
- reg_dst_out  out  4  registered
- reg_wr_out  out  1  registered write enable
- sp_out  out  32  current SP
- mem_err  out  1  one-cycle pulse on timeout abort

## Operation
- access = wb_sel_in | mem_wr_in. mem_we = mem_wr_in.
- Address: mem_addr_sel_in=0 -> alu_out_in. mem_addr_sel_in=1 -> push: SP-SP_STEP; pop or none: SP. Arithmetic is 32-bit modulo 2^32, so wrap-around is silent.
- SP update happens on the completing edge only, and only when the access completes with ack. Push writes SP-SP_STEP; pop writes SP+SP_STEP. There is no update on abort or on non-access instructions.
- FSM states: IDLE and WAIT.
  - IDLE, no access: pass-through. stall_out=0.
  - IDLE, access: mem_req=1.
    - If mem_ack is high the same cycle, the access completes with no stall.
    - Otherwise stall_out=1, go to WAIT, and clear the timeout counter.
  - WAIT: mem_req=1. mem_addr, mem_we and mem_wdata stay stable, because EX/MEM is held by the stall and SP is unchanged.
    - On mem_ack: stall_out=0 that cycle, complete, return to IDLE.
    - If the counter reaches TIMEOUT-1 without ack: stall_out=0, abort, pulse mem_err next cycle, return to IDLE.
    - Otherwise increment the counter and keep stall_out=1.
- Completion edge: wb_data_out <= wb_sel_in ? mem_rdata : alu_out_in; reg_dst_out <= reg_dst_in; reg_wr_out <= reg_wr_in.
- Stalled edge: reg_wr_out <= 0 (bubble to WB). wb_data_out and reg_dst_out hold.
- Abort edge: reg_wr_out <= 0 and SP holds.
- mem_ack while mem_req=0 is ignored.
- Reset values: SP=SP_INIT, state=IDLE, counter=0, wb_data_out=0, reg_dst_out=0, reg_wr_out=0, mem_err=0. mem_req/stall_out are 0 while rst_n is low.
- Reset mid-WAIT drops the request immediately. Any late ack is ignored.

## Timing
- Non-access instruction: one cycle; result visible on outputs one cycle after the inputs are presented.
- Access with ack k cycles after first mem_req cycle (k=0 same cycle): stall_out high for exactly k cycles, result registered on edge k+1.
- Back-to-back accesses: the next mem_req rises the cycle after the completing edge. There is no dead cycle beyond the handshake.
- Timeout: stall_out high TIMEOUT cycles, mem_req high TIMEOUT+1 cycles, mem_err high in the cycle after.
- sp_out reflects the new SP the cycle after the completing edge. A following push/pop uses the updated value.

## Test plan
- Reset then ALU op alu_out_in=0x1234, reg_wr=1, dst=3 -> next cycle wb_data_out=0x1234, reg_dst_out=3, reg_wr_out=1, mem_req never high, sp_out=0xFFFC.
- Load addr 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> stall_out high 3 cycles, reg_wr_out=0 during stall, then wb_data_out=0xDEADBEEF, reg_wr_out=1.
- Push (sp_select=01, mem_addr_sel=1, mem_wr=1, data 0xA5) with same-cycle ack -> mem_addr=0xFFF8, mem_we=1, no stall, sp_out=0xFFF8. Following pop with ack -> mem_addr=0xFFF8, sp_out=0xFFFC.
- SP_INIT=0, push -> mem_addr=0xFFFFFFFC, SP wraps to 0xFFFFFFFC. Pop -> SP returns to 0.
- Load with no ack, TIMEOUT=4 -> stall 4 cycles, mem_err one-cycle pulse, reg_wr_out=0, SP unchanged. Pipeline resumes.
- rst_n asserted during WAIT -> mem_req/stall_out drop immediately, outputs at reset values, an ack arriving afterward has no effect.
